// File: rtl/conv_pkg.sv
// conv_pkg: shared width derivation and saturation bounds for the conv output stage
package conv_pkg;
    function automatic int acc_bw(input int data_bw);
        return 2 * data_bw + 2;
    endfunction
    function automatic int sat_max(input int data_bw);
        return (1 << (data_bw - 1)) - 1;
    endfunction
    function automatic int sat_min(input int data_bw);
        return -(1 << (data_bw - 1));
    endfunction
    localparam int DEF_DATA_BW = 8;
    localparam int SAT_MAX = sat_max(DEF_DATA_BW);
    localparam int SAT_MIN = sat_min(DEF_DATA_BW);
endpackage

// File: rtl/conv_round_sat.sv
// conv_round_sat: round-half-up arithmetic shift, optional ReLU (CONV_OUT_RELU_EN), signed saturation
module conv_round_sat import conv_pkg::*; #(
    parameter int DATA_BW  = 8,
    parameter int SHIFT_BW = 5
) (
    input  logic signed [acc_bw(DATA_BW)-1:0] acc,
    input  logic        [SHIFT_BW-1:0]        shift,
    output logic        [DATA_BW-1:0]         pix
);
    localparam int ACC_BW = acc_bw(DATA_BW);
    localparam logic signed [ACC_BW-1:0] HI = ACC_BW'(sat_max(DATA_BW));
    localparam logic signed [ACC_BW-1:0] LO = ACC_BW'(sat_min(DATA_BW));
    logic signed [ACC_BW-1:0] rnd, shifted, clipped;
    always_comb begin
        rnd = (shift == '0) ? '0 : ACC_BW'(1) << (shift - SHIFT_BW'(1));
        shifted = (acc + rnd) >>> shift;
`ifdef CONV_OUT_RELU_EN
        clipped = shifted[ACC_BW-1] ? '0 : shifted;
`else
        clipped = shifted;
`endif
        pix = (clipped > HI) ? DATA_BW'(HI) : (clipped < LO) ? DATA_BW'(LO) : clipped[DATA_BW-1:0];
    end
endmodule

// File: rtl/conv_out_requant.sv
// conv_out_requant: 3-stage stallable bias/round/saturate output pipeline with tile counter; ReLU via CONV_OUT_RELU_EN
module conv_out_requant import conv_pkg::*; #(
    parameter int DATA_BW  = 8,
    parameter int NUM_OUT  = 64,
    parameter int SHIFT_BW = 5
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   PSUM_VALID,
    output logic                   PSUM_READY,
    input  logic [2*DATA_BW-1:0]   PSUM_IN,
    input  logic [2*DATA_BW-1:0]   BIAS_IN,
    input  logic [SHIFT_BW-1:0]    SHIFT_IN,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [DATA_BW-1:0]     OUT_DATA,
    output logic                   OUT_LAST,
    output logic                   DONE
);
    localparam int ACC_BW = acc_bw(DATA_BW);
    localparam int PS_BW  = 2 * DATA_BW;
    localparam int CNT_BW = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, done_q, done_d;
    logic [PS_BW-1:0]         psum1_q, psum1_d, bias1_q, bias1_d;
    logic [SHIFT_BW-1:0]      sh1_q, sh1_d, sh2_q, sh2_d;
    logic signed [ACC_BW-1:0] acc2_q, acc2_d;
    logic [DATA_BW-1:0]       pix3_q, pix3_d, pix_rs;
    logic [CNT_BW-1:0]        cnt_q, cnt_d;
    logic                     rdy1, rdy2, rdy3, out_acc, last;
    conv_round_sat #(.DATA_BW(DATA_BW), .SHIFT_BW(SHIFT_BW)) u_round_sat (
        .acc   (acc2_q),
        .shift (sh2_q),
        .pix   (pix_rs)
    );
    always_comb begin
        rdy3 = !v3_q || OUT_READY;
        rdy2 = !v2_q || rdy3;
        rdy1 = !v1_q || rdy2;
        v1_d = rdy1 ? PSUM_VALID : v1_q;
        psum1_d = (rdy1 && PSUM_VALID) ? PSUM_IN : psum1_q;
        bias1_d = (rdy1 && PSUM_VALID) ? BIAS_IN : bias1_q;
        sh1_d = (rdy1 && PSUM_VALID) ? SHIFT_IN : sh1_q;
        v2_d = rdy2 ? v1_q : v2_q;
        acc2_d = (rdy2 && v1_q) ? ACC_BW'($signed(psum1_q)) + ACC_BW'($signed(bias1_q)) : acc2_q;
        sh2_d = (rdy2 && v1_q) ? sh1_q : sh2_q;
        v3_d = rdy3 ? v2_q : v3_q;
        pix3_d = (rdy3 && v2_q) ? pix_rs : pix3_q;
        out_acc = v3_q && OUT_READY;
        last = cnt_q == CNT_BW'(NUM_OUT - 1);
        cnt_d = out_acc ? (last ? '0 : cnt_q + CNT_BW'(1)) : cnt_q;
        done_d = out_acc && last;
    end
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            psum1_q <= '0;
            bias1_q <= '0;
            sh1_q <= '0;
            acc2_q <= '0;
            sh2_q <= '0;
            pix3_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            psum1_q <= psum1_d;
            bias1_q <= bias1_d;
            sh1_q <= sh1_d;
            acc2_q <= acc2_d;
            sh2_q <= sh2_d;
            pix3_q <= pix3_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
        end
    end
    assign PSUM_READY = rdy1;
    assign OUT_VALID  = v3_q;
    assign OUT_DATA   = pix3_q;
    assign OUT_LAST   = v3_q && last;
    assign DONE       = done_q;
endmodule

// File: tb/tb_conv_out_requant.sv
// tb_conv_out_requant: scoreboard bench for conv_out_requant and standalone conv_round_sat
module tb_conv_out_requant;
    localparam int NO = 4;
    logic CLK = 1'b0, RSTN = 1'b0, PSUM_VALID = 1'b0, OUT_READY = 1'b1;
    logic PSUM_READY, OUT_VALID, OUT_LAST, DONE;
    logic [15:0] PSUM_IN = '0, BIAS_IN = '0;
    logic [4:0] SHIFT_IN = '0, rs_sh = '0;
    logic [7:0] OUT_DATA, rs_pix;
    logic signed [17:0] rs_acc = '0;
    int checks = 0, failures = 0, cyc = 0, cnt = 0, n_last = 0, n_done = 0, l0, d0;
    bit rnd_mode = 0, mon_en = 0, exp_done = 0, prev_stall = 0;
    logic [7:0] prev_data;
    logic prev_last;
    typedef struct {logic [7:0] d; int c; bit lat;} item_t;
    item_t q[$];
    item_t it;

    conv_out_requant #(.DATA_BW(8), .NUM_OUT(NO), .SHIFT_BW(5)) dut (
        .CLK(CLK), .RSTN(RSTN), .PSUM_VALID(PSUM_VALID), .PSUM_READY(PSUM_READY),
        .PSUM_IN(PSUM_IN), .BIAS_IN(BIAS_IN), .SHIFT_IN(SHIFT_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST), .DONE(DONE)
    );
    conv_round_sat #(.DATA_BW(8), .SHIFT_BW(5)) u_rs (.acc(rs_acc), .shift(rs_sh), .pix(rs_pix));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    function automatic logic [7:0] model(input int p, input int b, input int s);
        int v;
        v = (p + b + (s > 0 ? (1 << (s - 1)) : 0)) >>> s;
`ifdef CONV_OUT_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        OUT_READY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge CLK) if (mon_en) begin
        check("done", DONE, exp_done);
        check("psum_ready", PSUM_READY, (q.size() < 3) || OUT_READY);
        if (prev_stall) begin
            check("stall_valid", OUT_VALID, 1);
            check("stall_data", OUT_DATA, prev_data);
            check("stall_last", OUT_LAST, prev_last);
        end
        n_done += DONE;
        exp_done = 0;
        if (OUT_VALID && OUT_READY) begin
            check("q_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                it = q.pop_front();
                check("data", OUT_DATA, it.d);
                check("last", OUT_LAST, cnt == NO - 1);
                if (it.lat) check("latency", cyc - it.c, 3);
            end
            n_last += OUT_LAST;
            if (cnt == NO - 1) begin
                exp_done = 1;
                cnt = 0;
            end else cnt++;
        end
        if (PSUM_VALID && PSUM_READY)
            q.push_back('{d: model($signed(PSUM_IN), $signed(BIAS_IN), int'(SHIFT_IN)), c: cyc, lat: !rnd_mode});
        if (!RSTN) begin
            q.delete();
            cnt = 0;
            exp_done = 0;
        end
        prev_stall = RSTN && OUT_VALID && !OUT_READY;
        prev_data = OUT_DATA;
        prev_last = OUT_LAST;
    end

    task automatic send(input int p, input int b, input int s);
        int i;
        PSUM_IN = p[15:0];
        BIAS_IN = b[15:0];
        SHIFT_IN = s[4:0];
        PSUM_VALID = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (PSUM_READY) break;
        end
        check("accept_timeout", i < 200, 1);
        @(posedge CLK);
        #1;
        PSUM_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() > 0 || OUT_VALID); i++) @(negedge CLK);
        check("drain", q.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rs_acc = 18'sd5; rs_sh = 5'd1; #1;
        check("rs_half_pos", rs_pix, model(5, 0, 1));
        rs_acc = -18'sd5; #1;
        check("rs_half_neg", rs_pix, model(-5, 0, 1));
        rs_acc = 18'sd300; rs_sh = 5'd0; #1;
        check("rs_sat", rs_pix, 8'd127);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_data", OUT_DATA, 0);
        check("rst_out_last", OUT_LAST, 0);
        check("rst_done", DONE, 0);
        check("rst_psum_ready", PSUM_READY, 1);
        RSTN = 1'b1;
        mon_en = 1;
        send(100, -4, 0);
        drain();
        send(1000, 24, 3);
        send(-300, 0, 2);
        send(32767, 32767, 16);
        send(-32768, -32768, 0);
        drain();
        rnd_mode = 1;
        for (int k = 0; k < 10; k++)
            send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), int'($urandom_range(0, 16)));
        rnd_mode = 0;
        drain();
        RSTN = 1'b0;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        l0 = n_last;
        d0 = n_done;
        for (int k = 0; k < 9; k++) send(k * 37 - 150, 3, k % 3);
        drain();
        @(posedge CLK);
        #1;
        check("tile_lasts", n_last - l0, 2);
        check("tile_dones", n_done - d0, 2);
        send(50, 0, 0);
        send(60, 0, 0);
        RSTN = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_out_valid", OUT_VALID, 0);
        check("midrst_psum_ready", PSUM_READY, 1);
        RSTN = 1'b1;
        l0 = n_last;
        for (int k = 0; k < 4; k++) send(k * 10, 0, 1);
        drain();
        check("after_rst_last", n_last - l0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
